neural_mac_array: RTL
=====================

// Module: neural_mac_array
// PURPOSE
//   Parametrised successor of the single-neuron MAC. LANES neurons share one
//   streamed input vector; each lane has its own weight and bias. A packet of
//   input beats is accumulated at full precision, then the block applies bias,
//   rounding, saturation and optional ReLU. Results leave on a valid/ready port.
//   Sits between the feature buffer and the next layer's input FIFO.
// PARAMETERS
//   DW      16  signed two's-complement data/weight/bias width, Q(DW-FRAC).FRAC
//   FRAC    8   fraction bits; legal range 1..DW-1
//   LANES   4   number of parallel neurons
//   GUARD   8   accumulator guard bits; ACC_W = 2*DW+GUARD
//   CNT_W   10  width of the beat counter
// PORTS
//   clk        in   1           clock, rising edge
//   rst        in   1           synchronous, active-high reset
//   relu_en    in   1           sampled on the first beat of a packet
//   in_valid   in   1           input beat valid
//   in_ready   out  1           block accepts a beat
//   in_last    in   1           marks the final beat of a packet
//   in_data    in   DW          shared input sample
//   weight     in   LANES*DW    per-lane weight; lane i is [i*DW +: DW]
//   bias       in   LANES*DW    per-lane bias, sampled with the in_last beat
//   out_valid  out  1           result valid
//   out_ready  in   1           downstream accepts the result
//   out_data   out  LANES*DW    per-lane result
//   out_ovf    out  LANES       per-lane saturation flag
//   out_beats  out  CNT_W       beats accumulated in the packet
// BEHAVIOUR
//   Reset: state=IDLE; accumulators, out_data, out_ovf and out_beats = 0;
//     out_valid=0, in_ready=0 in the reset cycle, then 1 from the next cycle.
//   Beat accepted = in_valid & in_ready.
//   FSM: IDLE -beat-> ACC, or FINISH if in_last; ACC -beat & in_last-> FINISH;
//     FINISH -> OUT (always 1 cycle); OUT -out_valid & out_ready-> IDLE.
//   in_ready = 1 in IDLE and ACC only; 0 in FINISH and OUT.
//   First beat in IDLE loads acc = product. It does not add to the stale value.
//     Later beats do acc += in_data*weight_i (signed DWxDW -> 2DW, sign-extended).
//   Beat counter: +1 per accepted beat and saturates at 2^CNT_W-1. It is copied
//     to out_beats in FINISH and cleared on the first beat of the next packet.
//   Accumulator wraps modulo 2^ACC_W. GUARD sizing is the user's job, so no flag.
//   FINISH per lane: s = acc + (sext(bias)<<FRAC) + (1<<(FRAC-1)); r = s>>>FRAC.
//     This is round-half-up.
//     r > 2^(DW-1)-1 -> max, ovf=1; r < -2^(DW-1) -> min, ovf=1; else ovf=0.
//     If relu_en (as latched) and the saturated result is negative -> 0.
//     ovf keeps its value in that case.
//   Latency: in_last accepted at edge t -> out_valid=1 after edge t+2.
//   OUT holds out_data/out_ovf/out_beats stable until the handshake. After the
//     handshake, out_valid=0 and in_ready=1 on the next cycle. A result handshake
//     and a new input beat never share a cycle.
//   out_data keeps its last value after the handshake; only out_valid qualifies it.
//   weight is sampled every accepted beat; bias and weight are ignored otherwise.
//   in_last with no preceding beats (single-beat packet) is legal.
//   rst in any state aborts the packet and discards partial sums. A result held
//     in OUT is lost. The next packet starts clean.
// TESTING  (DW=16, FRAC=8, LANES=2 unless noted)
//   1 Basic: 3 beats in=0x0100, w=0x0200 both lanes, bias=0x0080
//     -> out_data lanes=0x0680, ovf=0, out_beats=3, out_valid 2 cycles after last.
//   2 Saturation: 4 beats in=0x7FFF, lane0 w=0x7FFF, lane1 w=0x8001
//     -> lane0=0x7FFF, lane1=0x8000, out_ovf=2'b11.
//   3 ReLU: 1 beat in=0xFF00, w=0x0100, bias=0 -> 0xFF00 with relu_en=0;
//     0x0000 with relu_en=1; ovf=0 in both cases.
//   4 Backpressure: hold out_ready=0 for 5 cycles -> out_data stable and
//     in_ready=0 throughout; after the handshake, the next packet is accepted
//     and its first beat does not include the previous sum.
//   5 Reset mid-packet: rst after 2 of 4 beats, then a new packet of
//     1 beat 0x0100 x 0x0100 -> 0x0100, out_beats=1.
//   6 Rounding: acc=0x0180 with bias=0 -> 0x0002; acc=-0x0180 -> 0xFFFF.
//     This checks round-half-up on both signs.

Source files
------------

// File: rtl/neural_mac_array_if.sv
// Stream bus for neural_mac_array: input beats with
// per-lane weight/bias, and a per-lane result port.
interface neural_mac_array_if #(
  parameter int DW    = 16,
  parameter int LANES = 4,
  parameter int CNT_W = 10
);
  logic                  relu_en;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_last;
  logic [DW-1:0]         in_data;
  logic [LANES*DW-1:0]   weight;
  logic [LANES*DW-1:0]   bias;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*DW-1:0]   out_data;
  logic [LANES-1:0]      out_ovf;
  logic [CNT_W-1:0]      out_beats;

  modport master (
    output relu_en, in_valid, in_last,
    output in_data, weight, bias, out_ready,
    input  in_ready, out_valid,
    input  out_data, out_ovf, out_beats
  );

  modport slave (
    input  relu_en, in_valid, in_last,
    input  in_data, weight, bias, out_ready,
    output in_ready, out_valid,
    output out_data, out_ovf, out_beats
  );
endinterface

// File: rtl/neural_mac_array.sv
// LANES-wide MAC over a shared input stream; bias,
// round-half-up, saturate, optional ReLU per lane.
// Ports: clk, rst (sync, active high), bus (slave).
module neural_mac_array #(
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int LANES = 4,
  parameter int GUARD = 8,
  parameter int CNT_W = 10
) (
  input logic               clk,
  input logic               rst,
  neural_mac_array_if.slave bus
);
  localparam int ACC_W = 2*DW + GUARD;
  localparam int S_W   = ACC_W + 1;

  localparam logic signed [S_W-1:0] MAXV =
    {{(S_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [S_W-1:0] MINV =
    {{(S_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE, ACC, FINISH, OUT
  } state_t;

  state_t r_state, w_next;

  logic                    r_in_ready;
  logic                    r_out_valid;
  logic                    r_relu;
  logic [LANES*DW-1:0]     r_bias;
  logic [LANES*DW-1:0]     r_out_data;
  logic [LANES-1:0]        r_ovf;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        r_beats;
  logic signed [ACC_W-1:0] r_acc [LANES];

  logic                    w_beat;
  logic                    w_done;
  logic [LANES*DW-1:0]     w_res;
  logic [LANES-1:0]        w_ovf;

  assign w_beat = bus.in_valid & r_in_ready;
  assign w_done = r_out_valid & bus.out_ready;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:
        if (w_beat)
          w_next = bus.in_last ? FINISH : ACC;
      ACC:
        if (w_beat && bus.in_last)
          w_next = FINISH;
      FINISH:
        w_next = OUT;
      OUT:
        if (w_done)
          w_next = IDLE;
      default:
        w_next = IDLE;
    endcase
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [DW-1:0]    w_x;
    logic signed [DW-1:0]    w_w;
    logic signed [DW-1:0]    w_b;
    logic signed [2*DW-1:0]  w_prod;
    logic signed [ACC_W-1:0] w_ext;
    logic signed [S_W-1:0]   w_s;
    logic signed [S_W-1:0]   w_r;
    logic [DW-1:0]           w_sat;
    logic                    w_o;

    assign w_x    = bus.in_data;
    assign w_w    = bus.weight[g*DW +: DW];
    assign w_b    = r_bias[g*DW +: DW];
    assign w_prod = w_x * w_w;
    assign w_ext  = {{GUARD{w_prod[2*DW-1]}}, w_prod};

    // Bias is aligned to the product's 2*FRAC
    // fraction; the half-LSB makes >>> round up.
    assign w_s =
      {r_acc[g][ACC_W-1], r_acc[g]} +
      ({{(S_W-DW){w_b[DW-1]}}, w_b} <<< FRAC) +
      (S_W'(1) <<< (FRAC-1));
    assign w_r = w_s >>> FRAC;

    always_comb begin
      w_sat = w_r[DW-1:0];
      w_o   = 1'b0;
      if (w_r > MAXV) begin
        w_sat = {1'b0, {(DW-1){1'b1}}};
        w_o   = 1'b1;
      end else if (w_r < MINV) begin
        w_sat = {1'b1, {(DW-1){1'b0}}};
        w_o   = 1'b1;
      end
      if (r_relu && w_sat[DW-1])
        w_sat = '0;
    end

    assign w_res[g*DW +: DW] = w_sat;
    assign w_ovf[g]          = w_o;

    always_ff @(posedge clk) begin
      if (rst)
        r_acc[g] <= '0;
      else if (w_beat)
        r_acc[g] <= (r_state == IDLE) ?
                    w_ext : r_acc[g] + w_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_relu      <= 1'b0;
      r_bias      <= '0;
      r_out_data  <= '0;
      r_ovf       <= '0;
      r_cnt       <= '0;
      r_beats     <= '0;
    end else begin
      r_state     <= w_next;
      r_in_ready  <= (w_next == IDLE) ||
                     (w_next == ACC);
      // Valid rises one cycle into OUT and drops
      // on the same edge that leaves OUT.
      r_out_valid <= (r_state == OUT) && !w_done;
      if (w_beat) begin
        if (r_state == IDLE) begin
          r_relu <= bus.relu_en;
          r_cnt  <= CNT_W'(1);
        end else if (r_cnt != '1) begin
          r_cnt  <= r_cnt + 1'b1;
        end
        if (bus.in_last)
          r_bias <= bus.bias;
      end
      if (r_state == FINISH) begin
        r_out_data <= w_res;
        r_ovf      <= w_ovf;
        r_beats    <= r_cnt;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_ovf   = r_ovf;
  assign bus.out_beats = r_beats;
endmodule
